// File: rtl/control_ascensor.sv
// control_ascensor: elevator motion/door controller for a four-floor car.
// Takes one one-hot target floor at a time, drives the car floor by floor
// with a travel timer, and holds the door open on arrival for a timed
// interval that the door button can extend.
module control_ascensor #(
  parameter int T_PISO   = 100,
  parameter int T_PUERTA = 200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] memoria,
  input  logic       sol_valida,
  output logic       sol_lista,
  input  logic       boton_puerta,
  output logic [1:0] piso,
  output logic       motor_subir,
  output logic       motor_bajar,
  output logic       puerta,
  output logic       llegada,
  output logic       error_sol
);

  localparam int TPW = (T_PISO   > 1) ? $clog2(T_PISO)   : 1;
  localparam int TDW = (T_PUERTA > 1) ? $clog2(T_PUERTA) : 1;

  localparam logic [TPW-1:0] PISO_FIN   = TPW'(T_PISO - 1);
  localparam logic [TDW-1:0] PUERTA_FIN = TDW'(T_PUERTA - 1);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    SUBIR  = 2'd1,
    BAJAR  = 2'd2,
    PUERTA = 2'd3
  } estado_t;

  estado_t        estado_q, estado_d;
  logic [1:0]     piso_q, piso_d;
  logic [1:0]     objetivo_q, objetivo_d;
  logic [TPW-1:0] timer_piso_q, timer_piso_d;
  logic [TDW-1:0] timer_puerta_q, timer_puerta_d;
  logic           sol_lista_q, sol_lista_d;
  logic           motor_subir_q, motor_subir_d;
  logic           motor_bajar_q, motor_bajar_d;
  logic           puerta_q, puerta_d;
  logic           llegada_q, llegada_d;
  logic           error_sol_q, error_sol_d;

  logic           sol_ok;
  logic [1:0]     sol_idx;
  logic           aceptar;
  logic [1:0]     piso_arriba;
  logic [1:0]     piso_abajo;

  // Decode the one-hot request; anything other than a single set bit is rejected.
  always_comb begin
    sol_ok  = 1'b1;
    sol_idx = 2'd0;
    case (memoria)
      4'b0001: sol_idx = 2'd0;
      4'b0010: sol_idx = 2'd1;
      4'b0100: sol_idx = 2'd2;
      4'b1000: sol_idx = 2'd3;
      default: sol_ok  = 1'b0;
    endcase
  end

  assign aceptar     = sol_valida && sol_lista_q;
  assign piso_arriba = piso_q + 2'd1;
  assign piso_abajo  = piso_q - 2'd1;

  // Next-state, floor, target and timer logic; also the one-cycle event pulses.
  always_comb begin
    estado_d       = estado_q;
    piso_d         = piso_q;
    objetivo_d     = objetivo_q;
    timer_piso_d   = timer_piso_q;
    timer_puerta_d = timer_puerta_q;
    llegada_d      = 1'b0;
    error_sol_d    = 1'b0;
    case (estado_q)
      REPOSO: begin
        timer_piso_d   = '0;
        timer_puerta_d = '0;
        if (aceptar) begin
          if (!sol_ok) begin
            error_sol_d = 1'b1;
          end else begin
            objetivo_d = sol_idx;
            if (sol_idx > piso_q) begin
              estado_d = SUBIR;
            end else if (sol_idx < piso_q) begin
              estado_d = BAJAR;
            end else begin
              // Already at the requested floor: open the door straight away.
              estado_d  = PUERTA;
              llegada_d = 1'b1;
            end
          end
        end
      end
      SUBIR: begin
        if (timer_piso_q == PISO_FIN) begin
          timer_piso_d = '0;
          piso_d       = piso_arriba;
          if (piso_arriba == objetivo_q) begin
            estado_d       = PUERTA;
            llegada_d      = 1'b1;
            timer_puerta_d = '0;
          end
        end else begin
          timer_piso_d = timer_piso_q + TPW'(1);
        end
      end
      BAJAR: begin
        if (timer_piso_q == PISO_FIN) begin
          timer_piso_d = '0;
          piso_d       = piso_abajo;
          if (piso_abajo == objetivo_q) begin
            estado_d       = PUERTA;
            llegada_d      = 1'b1;
            timer_puerta_d = '0;
          end
        end else begin
          timer_piso_d = timer_piso_q + TPW'(1);
        end
      end
      PUERTA: begin
        // The hold button restarts the open interval from zero every cycle it is pressed.
        if (boton_puerta) begin
          timer_puerta_d = '0;
        end else if (timer_puerta_q == PUERTA_FIN) begin
          timer_puerta_d = '0;
          estado_d       = REPOSO;
        end else begin
          timer_puerta_d = timer_puerta_q + TDW'(1);
        end
      end
      default: begin
        estado_d = REPOSO;
      end
    endcase
  end

  // Output decode from the next state, so every output is a register aligned with the state.
  always_comb begin
    sol_lista_d   = (estado_d == REPOSO);
    motor_subir_d = (estado_d == SUBIR);
    motor_bajar_d = (estado_d == BAJAR);
    puerta_d      = (estado_d == PUERTA);
  end

  // State and output registers; reset homes the car to floor 0 and idles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q       <= REPOSO;
      piso_q         <= 2'd0;
      objetivo_q     <= 2'd0;
      timer_piso_q   <= '0;
      timer_puerta_q <= '0;
      sol_lista_q    <= 1'b1;
      motor_subir_q  <= 1'b0;
      motor_bajar_q  <= 1'b0;
      puerta_q       <= 1'b0;
      llegada_q      <= 1'b0;
      error_sol_q    <= 1'b0;
    end else begin
      estado_q       <= estado_d;
      piso_q         <= piso_d;
      objetivo_q     <= objetivo_d;
      timer_piso_q   <= timer_piso_d;
      timer_puerta_q <= timer_puerta_d;
      sol_lista_q    <= sol_lista_d;
      motor_subir_q  <= motor_subir_d;
      motor_bajar_q  <= motor_bajar_d;
      puerta_q       <= puerta_d;
      llegada_q      <= llegada_d;
      error_sol_q    <= error_sol_d;
    end
  end

  assign sol_lista   = sol_lista_q;
  assign piso        = piso_q;
  assign motor_subir = motor_subir_q;
  assign motor_bajar = motor_bajar_q;
  assign puerta      = puerta_q;
  assign llegada     = llegada_q;
  assign error_sol   = error_sol_q;

endmodule

// File: tb/tb_control_ascensor.sv
// Directed bench for control_ascensor with default timing (100 / 200 cycles).
module tb_control_ascensor;

  logic       clk;
  logic       rst_n;
  logic [3:0] memoria;
  logic       sol_valida;
  logic       sol_lista;
  logic       boton_puerta;
  logic [1:0] piso;
  logic       motor_subir;
  logic       motor_bajar;
  logic       puerta;
  logic       llegada;
  logic       error_sol;

  int vectors;
  int miscompares;

  control_ascensor #(.T_PISO(100), .T_PUERTA(200)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .memoria     (memoria),
    .sol_valida  (sol_valida),
    .sol_lista   (sol_lista),
    .boton_puerta(boton_puerta),
    .piso        (piso),
    .motor_subir (motor_subir),
    .motor_bajar (motor_bajar),
    .puerta      (puerta),
    .llegada     (llegada),
    .error_sol   (error_sol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full output snapshot against expected values.
  task automatic chk_all(input string tag, input logic [1:0] e_piso, input logic e_sub,
                         input logic e_baj, input logic e_pue, input logic e_lleg,
                         input logic e_err, input logic e_lista);
    chk({tag, ".piso"},        {6'd0, piso},        {6'd0, e_piso});
    chk({tag, ".motor_subir"}, {7'd0, motor_subir}, {7'd0, e_sub});
    chk({tag, ".motor_bajar"}, {7'd0, motor_bajar}, {7'd0, e_baj});
    chk({tag, ".puerta"},      {7'd0, puerta},      {7'd0, e_pue});
    chk({tag, ".llegada"},     {7'd0, llegada},     {7'd0, e_lleg});
    chk({tag, ".error_sol"},   {7'd0, error_sol},   {7'd0, e_err});
    chk({tag, ".sol_lista"},   {7'd0, sol_lista},   {7'd0, e_lista});
    $display("step %s: piso=%0d sub=%0b baj=%0b pue=%0b lleg=%0b err=%0b lista=%0b",
             tag, piso, motor_subir, motor_bajar, puerta, llegada, error_sol, sol_lista);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    memoria      = 4'b0000;
    sol_valida   = 1'b0;
    boton_puerta = 1'b0;

    // Reset held 3 cycles, then idle with no requests.
    tick(3);
    chk_all("reset", 2'd0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b1;
    tick(5);
    chk_all("idle", 2'd0, 0, 0, 0, 0, 0, 1);

    // Up 0 -> 3: accept at edge k, floors at k+100/200/300.
    memoria = 4'b1000; sol_valida = 1'b1;
    tick(1);
    sol_valida = 1'b0;
    chk_all("up_accept", 2'd0, 1, 0, 0, 0, 0, 0);
    tick(99);
    chk_all("up_k99", 2'd0, 1, 0, 0, 0, 0, 0);
    tick(1);
    chk_all("up_k100", 2'd1, 1, 0, 0, 0, 0, 0);
    tick(100);
    chk_all("up_k200", 2'd2, 1, 0, 0, 0, 0, 0);
    tick(99);
    chk_all("up_k299", 2'd2, 1, 0, 0, 0, 0, 0);
    tick(1);
    chk_all("up_arrive", 2'd3, 0, 0, 1, 1, 0, 0);
    tick(1);
    chk_all("up_door", 2'd3, 0, 0, 1, 0, 0, 0);
    tick(198);
    chk_all("up_door_last", 2'd3, 0, 0, 1, 0, 0, 0);

    // Request presented on the closing edge must wait one cycle.
    memoria = 4'b0001; sol_valida = 1'b1;
    tick(1);
    chk_all("close_no_accept", 2'd3, 0, 0, 0, 0, 0, 1);
    tick(1);
    sol_valida = 1'b0;
    chk_all("down_accept", 2'd3, 0, 1, 0, 0, 0, 0);
    tick(100);
    chk_all("down_m100", 2'd2, 0, 1, 0, 0, 0, 0);
    tick(100);
    chk_all("down_m200", 2'd1, 0, 1, 0, 0, 0, 0);
    tick(99);
    chk_all("down_m299", 2'd1, 0, 1, 0, 0, 0, 0);
    tick(1);
    chk_all("down_arrive", 2'd0, 0, 0, 1, 1, 0, 0);
    tick(1);
    chk_all("down_door", 2'd0, 0, 0, 1, 0, 0, 0);
    tick(199);
    chk_all("down_closed", 2'd0, 0, 0, 0, 0, 0, 1);

    // Same-floor request opens the door immediately.
    memoria = 4'b0001; sol_valida = 1'b1;
    tick(1);
    sol_valida = 1'b0;
    chk_all("same_floor", 2'd0, 0, 0, 1, 1, 0, 0);
    tick(1);
    chk_all("same_floor_door", 2'd0, 0, 0, 1, 0, 0, 0);
    tick(199);
    chk_all("same_floor_closed", 2'd0, 0, 0, 0, 0, 0, 1);

    // Invalid requests: zero bits, then two bits.
    memoria = 4'b0000; sol_valida = 1'b1;
    tick(1);
    sol_valida = 1'b0;
    chk_all("err_zero", 2'd0, 0, 0, 0, 0, 1, 1);
    tick(1);
    chk_all("err_zero_end", 2'd0, 0, 0, 0, 0, 0, 1);
    memoria = 4'b0110; sol_valida = 1'b1;
    tick(1);
    sol_valida = 1'b0;
    chk_all("err_multi", 2'd0, 0, 0, 0, 0, 1, 1);
    tick(1);
    chk_all("err_multi_end", 2'd0, 0, 0, 0, 0, 0, 1);

    // Door hold: go to floor 2, press the button when the door timer reads 150.
    memoria = 4'b0100; sol_valida = 1'b1;
    tick(1);
    sol_valida = 1'b0;
    chk_all("hold_accept", 2'd0, 1, 0, 0, 0, 0, 0);
    tick(200);
    chk_all("hold_arrive", 2'd2, 0, 0, 1, 1, 0, 0);
    // Request held throughout the door phase; must not be taken until idle.
    memoria = 4'b0001; sol_valida = 1'b1;
    tick(150);
    chk_all("hold_t150", 2'd2, 0, 0, 1, 0, 0, 0);
    boton_puerta = 1'b1;
    tick(1);
    boton_puerta = 1'b0;
    tick(199);
    chk_all("hold_a350", 2'd2, 0, 0, 1, 0, 0, 0);
    tick(1);
    chk_all("hold_closed", 2'd2, 0, 0, 0, 0, 0, 1);
    tick(1);
    sol_valida = 1'b0;
    chk_all("held_req_accept", 2'd2, 0, 1, 0, 0, 0, 0);
    tick(200);
    chk_all("held_req_arrive", 2'd0, 0, 0, 1, 1, 0, 0);
    tick(200);
    chk_all("held_req_closed", 2'd0, 0, 0, 0, 0, 0, 1);

    // Button outside the door phase does nothing.
    boton_puerta = 1'b1;
    tick(3);
    boton_puerta = 1'b0;
    chk_all("btn_idle", 2'd0, 0, 0, 0, 0, 0, 1);

    // Reset mid-travel between floors 1 and 2.
    memoria = 4'b1000; sol_valida = 1'b1;
    tick(1);
    sol_valida = 1'b0;
    tick(150);
    chk_all("mid_travel", 2'd1, 1, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 2'd0, 0, 0, 0, 0, 0, 1);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    memoria = 4'b0010; sol_valida = 1'b1;
    tick(1);
    sol_valida = 1'b0;
    chk_all("post_reset_accept", 2'd0, 1, 0, 0, 0, 0, 0);
    tick(100);
    chk_all("post_reset_arrive", 2'd1, 0, 0, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
